// File: rtl/xnor_arbiter.sv
// xnor_arbiter: shares one WIDTH-bit XNOR (bitwise-equality) datapath among
// NREQ requesters. A round-robin arbiter grants one request per accepted cycle.
// The selected operand pair's XNOR is registered together with the winner's
// ID and an all-bits-match flag. Results are delivered over a valid/ready
// handshake.
// Optional feature: define XNOR_ARB_POPCOUNT_EN to add the RES_COUNT output,
// which carries the number of matching bits in the registered result.
module xnor_arbiter #(
  parameter  int WIDTH = 8,
  parameter  int NREQ  = 4,
  localparam int IDW   = $clog2(NREQ)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [NREQ-1:0]       REQ_VALID,
  input  logic [NREQ*WIDTH-1:0] REQ_A,
  input  logic [NREQ*WIDTH-1:0] REQ_B,
  output logic [NREQ-1:0]       REQ_READY,
  output logic                  RES_VALID,
  input  logic                  RES_READY,
  output logic [IDW-1:0]        RES_ID,
  output logic [WIDTH-1:0]      RES_DATA,
  output logic                  RES_MATCH
`ifdef XNOR_ARB_POPCOUNT_EN
  ,
  output logic [$clog2(WIDTH+1)-1:0] RES_COUNT
`endif
);

  // IDLE means no result is held; HOLD means a result is being offered.
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_HOLD = 1'b1;

  logic [0:0]       r_state;
  logic [IDW-1:0]   r_ptr;
  logic [IDW-1:0]   r_id;
  logic [WIDTH-1:0] r_data;
  logic             r_match;

  logic             w_open;
  logic             w_grantValid;
  logic [NREQ-1:0]  w_grant;
  logic [IDW-1:0]   w_grantIdx;
  logic [WIDTH-1:0] w_selA;
  logic [WIDTH-1:0] w_selB;
  logic [WIDTH-1:0] w_xnor;

  // The accept window is open when nothing is held, or when the held result
  // leaves this cycle. Reset closes it so that no handshake completes.
  assign w_open = !RST && ((r_state == S_IDLE) || RES_READY);

  // Round-robin search. It starts one past the last winner and wraps, so the
  // last winner has the lowest priority on the next grant.
  always_comb begin
    w_grant      = '0;
    w_grantIdx   = '0;
    w_grantValid = 1'b0;
    if (w_open) begin
      for (int k = 1; k <= NREQ; k++) begin
        if (!w_grantValid && REQ_VALID[IDW'((int'(r_ptr) + k) % NREQ)]) begin
          w_grantValid = 1'b1;
          w_grantIdx   = IDW'((int'(r_ptr) + k) % NREQ);
        end
      end
    end
    if (w_grantValid) begin
      w_grant[w_grantIdx] = 1'b1;
    end
  end

  // A single shared comparator is fed by the winning requester's operand pair.
  assign w_selA = REQ_A[w_grantIdx*WIDTH +: WIDTH];
  assign w_selB = REQ_B[w_grantIdx*WIDTH +: WIDTH];
  assign w_xnor = ~(w_selA ^ w_selB);

  assign REQ_READY = w_grant;

  // Controller state, round-robin pointer and result registers.
  // The data fields are loaded only on an accept, so they keep their last
  // value after the handshake drains the block back to IDLE.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_ptr   <= IDW'(NREQ - 1);
      r_id    <= '0;
      r_data  <= '0;
      r_match <= 1'b0;
    end else if (w_grantValid) begin
      r_state <= S_HOLD;
      r_ptr   <= w_grantIdx;
      r_id    <= w_grantIdx;
      r_data  <= w_xnor;
      r_match <= &w_xnor;
    end else if ((r_state == S_HOLD) && RES_READY) begin
      r_state <= S_IDLE;
    end
  end

  assign RES_VALID = (r_state == S_HOLD);
  assign RES_ID    = r_id;
  assign RES_DATA  = r_data;
  assign RES_MATCH = r_match;

`ifdef XNOR_ARB_POPCOUNT_EN
  localparam int CW = $clog2(WIDTH + 1);

  logic [CW-1:0] r_count;
  logic [CW-1:0] w_count;

  // Counts the matching bit positions of the comparator output.
  always_comb begin
    w_count = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_count = w_count + CW'(w_xnor[i]);
    end
  end

  // The count register is loaded and held exactly like RES_DATA.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_count <= '0;
    end else if (w_grantValid) begin
      r_count <= w_count;
    end
  end

  assign RES_COUNT = r_count;
`endif

endmodule

// File: tb/tb_xnor_arbiter.sv
// tb_xnor_arbiter: self-checking bench for xnor_arbiter. It applies a directed
// sequence with literal expectations, followed by protocol-following random
// traffic. A behavioural model checks every cycle against the DUT.
// Optional feature under test when defined: XNOR_ARB_POPCOUNT_EN.
module tb_xnor_arbiter;

  localparam int WIDTH = 8;
  localparam int NREQ  = 4;
  localparam int IDW   = 2;

  logic                  CLK = 1'b0;
  logic                  RST = 1'b1;
  logic [NREQ-1:0]       REQ_VALID = '0;
  logic [NREQ*WIDTH-1:0] REQ_A;
  logic [NREQ*WIDTH-1:0] REQ_B;
  logic [NREQ-1:0]       REQ_READY;
  logic                  RES_VALID;
  logic                  RES_READY = 1'b0;
  logic [IDW-1:0]        RES_ID;
  logic [WIDTH-1:0]      RES_DATA;
  logic                  RES_MATCH;
`ifdef XNOR_ARB_POPCOUNT_EN
  logic [3:0]            RES_COUNT;
`endif

  logic [WIDTH-1:0] opA [NREQ];
  logic [WIDTH-1:0] opB [NREQ];
  logic [NREQ-1:0]  lastGrant = '0;
  logic [NREQ-1:0]  vld;
  logic [WIDTH-1:0] keep;

  int tests = 0;
  int fails = 0;

  // Behavioural model state: the held result, and the index of the last winner.
  bit               mKnown = 1'b0;
  bit               mValid;
  int               mPtr;
  int               mId;
  logic [WIDTH-1:0] mData;
  bit               mMatch;
  int               mCount;

  xnor_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .REQ_VALID (REQ_VALID),
    .REQ_A     (REQ_A),
    .REQ_B     (REQ_B),
    .REQ_READY (REQ_READY),
    .RES_VALID (RES_VALID),
    .RES_READY (RES_READY),
    .RES_ID    (RES_ID),
    .RES_DATA  (RES_DATA),
    .RES_MATCH (RES_MATCH)
`ifdef XNOR_ARB_POPCOUNT_EN
    ,
    .RES_COUNT (RES_COUNT)
`endif
  );

  always #5 CLK = ~CLK;

  for (genvar g = 0; g < NREQ; g++) begin : g_pack
    assign REQ_A[g*WIDTH +: WIDTH] = opA[g];
    assign REQ_B[g*WIDTH +: WIDTH] = opB[g];
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic [NREQ-1:0] v, input logic rr);
    @(negedge CLK);
    RST       = rst;
    REQ_VALID = v;
    RES_READY = rr;
  endtask

  // Model and compare process. Inputs are driven at the negedge. This check
  // runs 2 time units later, then advances the model by one rising edge.
  initial begin
    logic [NREQ-1:0] expGrant;
    int              win;
    forever begin
      @(negedge CLK);
      #2;
      expGrant = '0;
      win      = -1;
      if (!RST && mKnown && (!mValid || RES_READY)) begin
        for (int k = 1; k <= NREQ; k++) begin
          if (win < 0 && REQ_VALID[(mPtr + k) % NREQ]) win = (mPtr + k) % NREQ;
        end
      end
      if (win >= 0) expGrant[win] = 1'b1;
      if (RST || mKnown) checkOutput("REQ_READY", REQ_READY, expGrant);
      if (mKnown) begin
        checkOutput("RES_VALID", RES_VALID, mValid);
        checkOutput("RES_ID", RES_ID, mId);
        checkOutput("RES_DATA", RES_DATA, mData);
        checkOutput("RES_MATCH", RES_MATCH, mMatch);
`ifdef XNOR_ARB_POPCOUNT_EN
        checkOutput("RES_COUNT", RES_COUNT, mCount);
`endif
      end
      if (RST) begin
        mKnown = 1'b1;
        mValid = 1'b0;
        mPtr   = NREQ - 1;
        mId    = 0;
        mData  = '0;
        mMatch = 1'b0;
        mCount = 0;
      end else if (mKnown) begin
        if (win >= 0) begin
          mValid = 1'b1;
          mPtr   = win;
          mId    = win;
          mData  = ~(opA[win] ^ opB[win]);
          mMatch = (opA[win] == opB[win]);
          mCount = $countones(mData);
        end else if (mValid && RES_READY) begin
          mValid = 1'b0;
        end
      end
      lastGrant = expGrant;
    end
  end

  // Directed scenarios with literal expectations, followed by random traffic.
  initial begin
    for (int i = 0; i < NREQ; i++) begin
      opA[i] = '0;
      opB[i] = '0;
    end

    // Reset values.
    applyStimulus(1'b1, 4'b0000, 1'b0);
    applyStimulus(1'b1, 4'b0000, 1'b0);
    applyStimulus(1'b0, 4'b0000, 1'b0);
    #3;
    checkOutput("rst_valid", RES_VALID, 0);
    checkOutput("rst_data", RES_DATA, 0);
    checkOutput("rst_id", RES_ID, 0);
    checkOutput("rst_match", RES_MATCH, 0);

    // Single request from requester 2.
    opA[2] = 8'hA5;
    opB[2] = 8'hA4;
    applyStimulus(1'b0, 4'b0100, 1'b1);
    #3;
    checkOutput("single_ready", REQ_READY, 4'b0100);
    applyStimulus(1'b0, 4'b0000, 1'b0);
    #3;
    checkOutput("single_valid", RES_VALID, 1);
    checkOutput("single_id", RES_ID, 2);
    checkOutput("single_data", RES_DATA, 8'hFE);
    checkOutput("single_match", RES_MATCH, 0);
`ifdef XNOR_ARB_POPCOUNT_EN
    checkOutput("single_count", RES_COUNT, 7);
`endif

    // Equal operands from requester 1, back to back with the held result.
    opA[1] = 8'h3C;
    opB[1] = 8'h3C;
    applyStimulus(1'b0, 4'b0010, 1'b1);
    #3;
    checkOutput("equal_ready", REQ_READY, 4'b0010);
    applyStimulus(1'b0, 4'b0000, 1'b0);
    #3;
    checkOutput("equal_id", RES_ID, 1);
    checkOutput("equal_data", RES_DATA, 8'hFF);
    checkOutput("equal_match", RES_MATCH, 1);
`ifdef XNOR_ARB_POPCOUNT_EN
    checkOutput("equal_count", RES_COUNT, 8);
`endif

    // Round-robin with all requesters valid, starting from a fresh reset.
    for (int i = 0; i < NREQ; i++) begin
      opA[i] = WIDTH'($urandom);
      opB[i] = WIDTH'($urandom);
    end
    applyStimulus(1'b1, 4'b0000, 1'b0);
    for (int j = 0; j < 5; j++) begin
      applyStimulus(1'b0, 4'b1111, 1'b1);
      #3;
      checkOutput("rr_ready", REQ_READY, 32'(1) << (j % 4));
      if (j > 0) checkOutput("rr_id", RES_ID, (j - 1) % 4);
    end

    // Backpressure: nothing is accepted and the held result stays stable.
    for (int j = 0; j < 5; j++) begin
      applyStimulus(1'b0, 4'b1111, 1'b0);
      #3;
      checkOutput("bp_ready", REQ_READY, 0);
      checkOutput("bp_id", RES_ID, 0);
      checkOutput("bp_valid", RES_VALID, 1);
    end
    applyStimulus(1'b0, 4'b1111, 1'b1);
    #3;
    checkOutput("bp_release_ready", REQ_READY, 4'b0010);

    // Reset while a result is held.
    applyStimulus(1'b0, 4'b0000, 1'b0);
    #3;
    checkOutput("mid_hold_valid", RES_VALID, 1);
    checkOutput("mid_hold_id", RES_ID, 1);
    applyStimulus(1'b1, 4'b1111, 1'b1);
    #3;
    checkOutput("mid_rst_ready", REQ_READY, 0);
    applyStimulus(1'b0, 4'b1111, 1'b1);
    #3;
    checkOutput("post_rst_valid", RES_VALID, 0);
    checkOutput("post_rst_data", RES_DATA, 0);
    checkOutput("post_rst_ready", REQ_READY, 4'b0001);

    // Drain to idle: RES_DATA keeps the last result.
    keep = ~(opA[0] ^ opB[0]);
    applyStimulus(1'b0, 4'b0000, 1'b1);
    #3;
    checkOutput("drain_valid_hi", RES_VALID, 1);
    checkOutput("drain_id", RES_ID, 0);
    applyStimulus(1'b0, 4'b0000, 1'b1);
    #3;
    checkOutput("drain_valid_lo", RES_VALID, 0);
    checkOutput("drain_data", RES_DATA, keep);

    // Random traffic. Requesters hold their operands until granted, and may
    // occasionally withdraw a request.
    vld = '0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge CLK);
      for (int i = 0; i < NREQ; i++) begin
        if (vld[i] && !lastGrant[i]) begin
          if ($urandom_range(0, 19) == 0) vld[i] = 1'b0;
        end else begin
          vld[i] = ($urandom_range(0, 1) == 1);
          if (vld[i]) begin
            opA[i] = WIDTH'($urandom);
            opB[i] = ($urandom_range(0, 3) == 0) ? opA[i] : WIDTH'($urandom);
          end
        end
      end
      RST       = ($urandom_range(0, 199) == 0);
      REQ_VALID = vld;
      RES_READY = ($urandom_range(0, 9) < 7);
    end

    @(negedge CLK);
    #5;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
